evdb_lane_buffer: RTL

// - Evict data buffer (EVDB) front-end. Sits directly downstream of the south-channel read/evict split.
// - Accepts up to 4 evict beats per cycle, one per hash lane, valid-only with no ready.
// - Stores them in per-lane FIFOs and drains them one beat per cycle, round-robin, to the

---
 rtl/vector_cache_pkg.sv | 16 +
 rtl/vc_sync_fifo.sv | 53 +++++
 rtl/evdb_lane_buffer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and EVDB sizing constants.
package vector_cache_pkg;

    localparam int unsigned EVDB_LANE_NUM   = 4;
    localparam int unsigned EVDB_FIFO_DEPTH = 4;

    localparam int unsigned GROUP_TAG_W  = 8;
    localparam int unsigned GROUP_DATA_W = 32;

    // One evict beat travelling from the south-channel split to write-back.
    typedef struct packed {
        logic [GROUP_TAG_W-1:0]  tag;
        logic [GROUP_DATA_W-1:0] data;
    } group_data_pld_t;

endpackage

// File: rtl/vc_sync_fifo.sv
// Single-clock FIFO with occupancy counter; callers must qualify push against full.
module vc_sync_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is not reset; only valid entries are ever observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty));
`endif

endmodule

// File: rtl/evdb_lane_buffer.sv
// EVDB front-end: per-lane evict FIFOs drained round-robin with credit return.
module evdb_lane_buffer
    import vector_cache_pkg::*;
#(
    parameter int unsigned LANE_NUM   = EVDB_LANE_NUM,
    parameter int unsigned FIFO_DEPTH = EVDB_FIFO_DEPTH,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [LANE_NUM-1:0]              evict_data_in_vld,
    input  group_data_pld_t [LANE_NUM-1:0]   evict_data_in,
    output logic                             evict_out_vld,
    input  logic                             evict_out_rdy,
    output group_data_pld_t                  evict_out_pld,
    output logic [1:0]                       evict_out_lane,
    output logic [LANE_NUM-1:0]              evict_credit_rtn,
    output logic                             evict_ovf_err,
    output logic [CNT_W*LANE_NUM-1:0]        lane_cnt
);

    localparam int unsigned LANE_W = 2;

    group_data_pld_t     head     [LANE_NUM];
    logic [CNT_W-1:0]    fifo_cnt [LANE_NUM];
    logic [LANE_NUM-1:0] full;
    logic [LANE_NUM-1:0] empty;
    logic [LANE_NUM-1:0] non_empty;
    logic [LANE_NUM-1:0] push_acc;
    logic [LANE_NUM-1:0] drop;
    logic [LANE_NUM-1:0] pop;

    logic [LANE_W-1:0]   rr_ptr;
    logic [LANE_W-1:0]   rr_grant;
    logic [LANE_W-1:0]   rr_idx;
    logic                rr_found;
    logic [LANE_W-1:0]   grant;
    logic                lock_vld;
    logic [LANE_W-1:0]   lock_lane;
    logic                xfer;

    // Per-lane storage.
    for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
        vc_sync_fifo #(
            .T     (group_data_pld_t),
            .DEPTH (FIFO_DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_acc[i]),
            .push_data (evict_data_in[i]),
            .pop       (pop[i]),
            .head      (head[i]),
            .cnt       (fifo_cnt[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
        assign lane_cnt[i*CNT_W +: CNT_W] = fifo_cnt[i];
    end

    assign non_empty = ~empty;

    // Round-robin search over non-empty lanes starting at rr_ptr; lane 0 when idle.
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned k = 0; k < LANE_NUM; k++) begin
            rr_idx = rr_ptr + LANE_W'(k);
            if (!rr_found && non_empty[rr_idx]) begin
                rr_grant = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // A stalled grant is held so the output stays stable until it transfers.
    assign grant         = lock_vld ? lock_lane : rr_grant;
    assign evict_out_vld = |non_empty;
    assign xfer          = evict_out_vld && evict_out_rdy;
    assign evict_out_lane = grant;
    assign evict_out_pld  = evict_out_vld ? head[grant] : '0;

    // Pop only the granted lane on a handshake.
    always_comb begin
        pop        = '0;
        pop[grant] = xfer;
    end

    // A same-cycle pop frees the slot a push into a full lane needs.
    assign push_acc = evict_data_in_vld & (~full | pop);
    assign drop     = evict_data_in_vld & full & ~pop;

    // Grant lock and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld  <= 1'b0;
            lock_lane <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            lock_vld  <= 1'b0;
            rr_ptr    <= grant + LANE_W'(1);
        end else if (evict_out_vld) begin
            lock_vld  <= 1'b1;
            lock_lane <= grant;
        end
    end

    // Credit pulse one cycle after each pop; sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evict_credit_rtn <= '0;
            evict_ovf_err    <= 1'b0;
        end else begin
            evict_credit_rtn <= pop;
            evict_ovf_err    <= evict_ovf_err | (|drop);
        end
    end

`ifndef SYNTHESIS
    a_credit_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(evict_credit_rtn));
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (evict_out_vld && !evict_out_rdy) |=>
            (evict_out_vld && evict_out_lane == $past(evict_out_lane)
                           && evict_out_pld == $past(evict_out_pld)));
`endif

endmodule
